// File: rtl/ica_cordic_arbiter.sv
// Round-robin owner of the shared CORDIC ICA vec/rot1 port pair.
// Idle-grant watchdog is built only when CORDIC_ARB_TIMEOUT_EN is defined.
module ica_cordic_arbiter #(
  parameter int N_REQ          = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int CORDIC_STAGES  = 16,
  parameter int RST_CYCLES     = 2,
  parameter int MAX_OUT        = 15,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           nreset,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               rel,
  output logic [N_REQ-1:0]               gnt,
  input  logic [N_REQ-1:0]               r_vec_en,
  input  logic [N_REQ-1:0]               r_vec_angle_calc_en,
  input  logic [N_REQ-1:0]               r_rot1_en,
  input  logic [N_REQ-1:0]               r_rot1_angle_microRot_n,
  input  logic [N_REQ-1:0]               r_rot1_microRot_ext_vld,
  input  logic [N_REQ*DATA_WIDTH-1:0]    r_vec_xin,
  input  logic [N_REQ*DATA_WIDTH-1:0]    r_vec_yin,
  input  logic [N_REQ*DATA_WIDTH-1:0]    r_rot1_xin,
  input  logic [N_REQ*DATA_WIDTH-1:0]    r_rot1_yin,
  input  logic [N_REQ*CORDIC_STAGES-1:0] r_rot1_microRot,
  input  logic [N_REQ*2-1:0]             r_rot1_quad,
  output logic                           ica_cordic_vec_en,
  output logic                           ica_cordic_vec_angle_calc_en,
  output logic                           ica_cordic_rot1_en,
  output logic                           ica_cordic_rot1_angle_microRot_n,
  output logic                           ica_cordic_rot1_microRot_ext_vld,
  output logic [DATA_WIDTH-1:0]          ica_cordic_vec_xin,
  output logic [DATA_WIDTH-1:0]          ica_cordic_vec_yin,
  output logic [DATA_WIDTH-1:0]          ica_cordic_rot1_xin,
  output logic [DATA_WIDTH-1:0]          ica_cordic_rot1_yin,
  output logic [CORDIC_STAGES-1:0]       ica_cordic_rot1_microRot_in,
  output logic [1:0]                     ica_cordic_rot1_quad_in,
  output logic                           cordic_nrst,
  input  logic                           cordic_vec_opvld,
  input  logic                           cordic_rot1_opvld,
  output logic [N_REQ-1:0]               r_vec_opvld,
  output logic [N_REQ-1:0]               r_rot1_opvld,
  output logic                           busy,
  output logic                           timeout
);

  localparam int IW = $clog2(N_REQ);
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int CW = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    CRST,
    GRANT,
    DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [RW-1:0]   rcnt_q, rcnt_d;
  logic [CW-1:0]   vout_q, rout_q;
  logic [N_REQ-1:0] gnt_q;
  logic            nrst_q;
  logic [IW:0]     sel;
  logic            grant, route, tmo_fire;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(N_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  // {found, index} of the first requester at or after start
  function automatic logic [IW:0] pick(
    input logic [N_REQ-1:0] r,
    input logic [IW-1:0]    start
  );
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    idx = start;
    for (int k = 0; k < N_REQ; k++) begin
      if (!res[IW] && r[idx]) res = {1'b1, idx};
      idx = inc(idx);
    end
    return res;
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [N_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [CW-1:0] step(
    input logic [CW-1:0] c,
    input logic          up,
    input logic          dn
  );
    logic [CW-1:0] r;
    r = c;
    if (up && !dn && c != CW'(MAX_OUT)) r = c + 1'b1;
    else if (dn && !up && c != '0) r = c - 1'b1;
    return r;
  endfunction

  assign grant = (state_q == GRANT);
  assign route = (state_q == GRANT) || (state_q == DRAIN);
  assign sel   = pick(req, ptr_q);

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q;
  logic          activity, idle_hit, timeout_q;
  logic [IW:0]   tsel;

  assign activity = ica_cordic_vec_en | ica_cordic_rot1_en
                  | cordic_vec_opvld | cordic_rot1_opvld;
  assign idle_hit = grant && !activity
                  && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
  assign tsel     = pick(req, inc(owner_q));
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    rcnt_d   = rcnt_q;
    tmo_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel[IW]) begin
          state_d = CRST;
          owner_d = sel[IW-1:0];
          rcnt_d  = '0;
        end
      end
      CRST: begin
        if (rcnt_q == RW'(RST_CYCLES - 1)) state_d = GRANT;
        else rcnt_d = rcnt_q + 1'b1;
      end
      GRANT: begin
        if (rel[owner_q]) begin
          state_d = DRAIN;
          ptr_d   = inc(owner_q);
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (idle_hit) begin
          state_d  = CRST;
          rcnt_d   = '0;
          tmo_fire = 1'b1;
          ptr_d    = inc(owner_q);
          owner_d  = tsel[IW] ? tsel[IW-1:0] : inc(owner_q);
        end
`endif
      end
      DRAIN: begin
        if (vout_q == '0 && rout_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      rcnt_q  <= '0;
      vout_q  <= '0;
      rout_q  <= '0;
      gnt_q   <= '0;
      nrst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      rcnt_q  <= rcnt_d;
      gnt_q   <= (state_d == GRANT) ? onehot(owner_d) : '0;
      nrst_q  <= (state_d != CRST);
      if (tmo_fire) begin
        vout_q <= '0;
        rout_q <= '0;
      end else begin
        vout_q <= step(vout_q, ica_cordic_vec_en, cordic_vec_opvld);
        rout_q <= step(rout_q, ica_cordic_rot1_en, cordic_rot1_opvld);
      end
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!nreset) begin
      tcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (grant && !activity && !idle_hit) tcnt_q <= tcnt_q + 1'b1;
      else tcnt_q <= '0;
      if (tmo_fire) timeout_q <= 1'b1;
      else if (state_q == CRST && state_d == GRANT) timeout_q <= 1'b0;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
`endif

  assign gnt         = gnt_q;
  assign cordic_nrst = nrst_q;
  assign busy        = (state_q != IDLE);

  assign ica_cordic_vec_en =
    grant & r_vec_en[owner_q];
  assign ica_cordic_vec_angle_calc_en =
    grant & r_vec_angle_calc_en[owner_q];
  assign ica_cordic_rot1_en =
    grant & r_rot1_en[owner_q];
  assign ica_cordic_rot1_angle_microRot_n =
    grant & r_rot1_angle_microRot_n[owner_q];
  assign ica_cordic_rot1_microRot_ext_vld =
    grant & r_rot1_microRot_ext_vld[owner_q];

  assign ica_cordic_vec_xin = grant ?
    r_vec_xin[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ica_cordic_vec_yin = grant ?
    r_vec_yin[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ica_cordic_rot1_xin = grant ?
    r_rot1_xin[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ica_cordic_rot1_yin = grant ?
    r_rot1_yin[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign ica_cordic_rot1_microRot_in = grant ?
    r_rot1_microRot[int'(owner_q)*CORDIC_STAGES +: CORDIC_STAGES] : '0;
  assign ica_cordic_rot1_quad_in = grant ?
    r_rot1_quad[int'(owner_q)*2 +: 2] : '0;

  // strobes follow the owner until its in-flight work has drained
  assign r_vec_opvld  = (route && cordic_vec_opvld) ? onehot(owner_q) : '0;
  assign r_rot1_opvld = (route && cordic_rot1_opvld) ? onehot(owner_q) : '0;

endmodule

// File: tb/tb_ica_cordic_arbiter.sv
// Bench for ica_cordic_arbiter: directed scenarios checked against
// a cycle-level ownership model plus hand-computed literal values.
module tb_ica_cordic_arbiter;

  localparam int N   = 2;
  localparam int DW  = 32;
  localparam int CS  = 16;
  localparam int RST = 2;
  localparam int MO  = 15;
  localparam int TMO = 16;

  logic clk, nreset;
  logic [N-1:0] req, rel, gnt;
  logic [N-1:0] r_vec_en, r_vec_angle_calc_en, r_rot1_en;
  logic [N-1:0] r_rot1_angle_microRot_n, r_rot1_microRot_ext_vld;
  logic [N*DW-1:0] r_vec_xin, r_vec_yin, r_rot1_xin, r_rot1_yin;
  logic [N*CS-1:0] r_rot1_microRot;
  logic [N*2-1:0]  r_rot1_quad;
  logic c_vec_en, c_vac_en, c_rot_en, c_rot_amn, c_rot_ext;
  logic [DW-1:0] c_vx, c_vy, c_rx, c_ry;
  logic [CS-1:0] c_mr;
  logic [1:0]    c_q;
  logic cordic_nrst, cordic_vec_opvld, cordic_rot1_opvld;
  logic [N-1:0] r_vec_opvld, r_rot1_opvld;
  logic busy, timeout;

  int n_chk = 0;
  int n_fail = 0;
  bit seen_tmo = 0;

  ica_cordic_arbiter #(
    .N_REQ(N), .DATA_WIDTH(DW), .CORDIC_STAGES(CS),
    .RST_CYCLES(RST), .MAX_OUT(MO), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .nreset(nreset), .req(req), .rel(rel), .gnt(gnt),
    .r_vec_en(r_vec_en),
    .r_vec_angle_calc_en(r_vec_angle_calc_en),
    .r_rot1_en(r_rot1_en),
    .r_rot1_angle_microRot_n(r_rot1_angle_microRot_n),
    .r_rot1_microRot_ext_vld(r_rot1_microRot_ext_vld),
    .r_vec_xin(r_vec_xin), .r_vec_yin(r_vec_yin),
    .r_rot1_xin(r_rot1_xin), .r_rot1_yin(r_rot1_yin),
    .r_rot1_microRot(r_rot1_microRot), .r_rot1_quad(r_rot1_quad),
    .ica_cordic_vec_en(c_vec_en),
    .ica_cordic_vec_angle_calc_en(c_vac_en),
    .ica_cordic_rot1_en(c_rot_en),
    .ica_cordic_rot1_angle_microRot_n(c_rot_amn),
    .ica_cordic_rot1_microRot_ext_vld(c_rot_ext),
    .ica_cordic_vec_xin(c_vx), .ica_cordic_vec_yin(c_vy),
    .ica_cordic_rot1_xin(c_rx), .ica_cordic_rot1_yin(c_ry),
    .ica_cordic_rot1_microRot_in(c_mr),
    .ica_cordic_rot1_quad_in(c_q),
    .cordic_nrst(cordic_nrst),
    .cordic_vec_opvld(cordic_vec_opvld),
    .cordic_rot1_opvld(cordic_rot1_opvld),
    .r_vec_opvld(r_vec_opvld), .r_rot1_opvld(r_rot1_opvld),
    .busy(busy), .timeout(timeout)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the port, how many reset cycles remain,
  // whether it is draining, and outstanding ops per path.
  bit m_valid = 0, m_has, m_drain, m_tmo, m_nrst;
  int m_owner, m_crst, m_vout, m_rout, m_ptr, m_idle;

  function bit m_granted();
    return m_has && m_crst == 0 && !m_drain;
  endfunction

  function int nxt_cnt(input int c, input bit up, input bit dn);
    if (up && !dn) return (c < MO) ? c + 1 : MO;
    if (dn && !up) return (c > 0) ? c - 1 : 0;
    return c;
  endfunction

  task automatic model_step();
    bit g, ve, re, act;
    int nv, nr;
    if (!nreset) begin
      m_has = 0; m_drain = 0; m_crst = 0; m_owner = 0;
      m_vout = 0; m_rout = 0; m_ptr = 0; m_idle = 0;
      m_tmo = 0; m_nrst = 0; m_valid = 1;
      return;
    end
    g  = m_granted();
    ve = g && r_vec_en[m_owner];
    re = g && r_rot1_en[m_owner];
    nv = nxt_cnt(m_vout, ve, cordic_vec_opvld);
    nr = nxt_cnt(m_rout, re, cordic_rot1_opvld);
    act = ve || re || cordic_vec_opvld || cordic_rot1_opvld;
    if (!m_has) begin
      for (int k = 0; k < N; k++)
        if (!m_has && req[(m_ptr + k) % N]) begin
          m_has = 1; m_owner = (m_ptr + k) % N; m_crst = RST;
        end
    end else if (m_crst > 0) begin
      m_crst--;
      if (m_crst == 0) begin m_tmo = 0; m_idle = 0; end
    end else if (!m_drain) begin
      if (rel[m_owner]) begin
        m_drain = 1; m_ptr = (m_owner + 1) % N;
      end
`ifdef CORDIC_ARB_TIMEOUT_EN
      else begin
        m_idle = act ? 0 : m_idle + 1;
        if (m_idle == TMO) begin
          bit f;
          f = 0;
          m_tmo = 1; nv = 0; nr = 0; m_idle = 0;
          m_ptr = (m_owner + 1) % N;
          m_owner = m_ptr;
          for (int k = 0; k < N; k++)
            if (!f && req[(m_ptr + k) % N]) begin
              f = 1; m_owner = (m_ptr + k) % N;
            end
          m_crst = RST;
        end
      end
`endif
    end else if (m_vout == 0 && m_rout == 0) begin
      m_has = 0; m_drain = 0;
    end
    m_vout = nv;
    m_rout = nr;
    m_nrst = !(m_has && m_crst > 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    logic [N-1:0] eg, ev, er;
    bit g, rt;
    @(negedge clk);
    if (timeout === 1'b1) seen_tmo = 1;
    if (m_valid) begin
      g  = m_granted();
      rt = m_has && m_crst == 0;
      eg = g ? N'(1) << m_owner : '0;
      ev = (rt && cordic_vec_opvld) ? N'(1) << m_owner : '0;
      er = (rt && cordic_rot1_opvld) ? N'(1) << m_owner : '0;
      check("m_gnt", gnt, eg);
      check("m_nrst", cordic_nrst, m_nrst);
      check("m_busy", busy, m_has);
      check("m_timeout", timeout, m_tmo);
      check("m_vec_opvld", r_vec_opvld, ev);
      check("m_rot1_opvld", r_rot1_opvld, er);
      check("m_en", {c_vec_en, c_vac_en, c_rot_en, c_rot_amn, c_rot_ext},
            g ? {r_vec_en[m_owner], r_vec_angle_calc_en[m_owner],
                 r_rot1_en[m_owner], r_rot1_angle_microRot_n[m_owner],
                 r_rot1_microRot_ext_vld[m_owner]} : 5'b0);
      check("m_vx", c_vx, g ? r_vec_xin[m_owner*DW +: DW] : '0);
      check("m_vy", c_vy, g ? r_vec_yin[m_owner*DW +: DW] : '0);
      check("m_rx", c_rx, g ? r_rot1_xin[m_owner*DW +: DW] : '0);
      check("m_ry", c_ry, g ? r_rot1_yin[m_owner*DW +: DW] : '0);
      check("m_mr", c_mr, g ? r_rot1_microRot[m_owner*CS +: CS] : '0);
      check("m_quad", c_q, g ? r_rot1_quad[m_owner*2 +: 2] : '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input logic [N-1:0] want, input int budget);
    int i = 0;
    while (gnt !== want && i < budget) begin tick(); i++; end
    check("wait_gnt", gnt, want);
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (busy !== 1'b0 && i < budget) begin tick(); i++; end
    check("wait_idle", busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 0; req = 0; rel = 0;
    r_vec_en = 0; r_vec_angle_calc_en = 0; r_rot1_en = 0;
    r_rot1_angle_microRot_n = 0; r_rot1_microRot_ext_vld = 0;
    r_vec_xin = 0; r_vec_yin = 0; r_rot1_xin = 0; r_rot1_yin = 0;
    r_rot1_microRot = 0; r_rot1_quad = 0;
    cordic_vec_opvld = 0; cordic_rot1_opvld = 0;

    // reset
    repeat (3) tick();
    check("rst_gnt", gnt, 0);
    check("rst_nrst", cordic_nrst, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_vec_en", c_vec_en, 0);
    nreset = 1;
    tick();
    check("rel_nrst", cordic_nrst, 1);

    // single grant with data muxing and strobe routing
    r_vec_xin = {32'hDEADBEEF, 32'h00100000};
    r_vec_yin = {32'h11111111, 32'h22222222};
    req = 2'b01;
    tick();
    check("sg_nrst0", cordic_nrst, 0);
    check("sg_gnt0", gnt, 0);
    tick();
    check("sg_nrst1", cordic_nrst, 0);
    tick();
    check("sg_gnt", gnt, 2'b01);
    check("sg_nrst_hi", cordic_nrst, 1);
    req = 0;
    r_vec_en = 2'b11;
    #1;
    check("sg_en", c_vec_en, 1);
    check("sg_xin", c_vx, 32'h00100000);
    tick();
    r_vec_en = 0;
    cordic_vec_opvld = 1;
    #1;
    check("sg_opvld", r_vec_opvld, 2'b01);
    tick();
    cordic_vec_opvld = 0;
    rel = 2'b01;
    tick();
    rel = 0;
    check("sg_rel_gnt", gnt, 0);
    check("sg_rel_busy", busy, 1);
    tick();
    check("sg_idle", busy, 0);

    // contention from a fresh reset: 0, then 1, then 0
    nreset = 0;
    tick();
    nreset = 1;
    req = 2'b11;
    wait_gnt(2'b01, 8);
    req = 2'b10;
    rel = 2'b01;
    tick();
    rel = 0;
    wait_gnt(2'b10, 12);
    req = 2'b01;
    rel = 2'b10;
    repeat (3) tick();
    rel = 0;
    wait_gnt(2'b01, 12);
    req = 0;
    rel = 2'b01;
    tick();
    rel = 0;
    wait_idle(8);

    // drain with three outstanding vec ops
    req = 2'b01;
    wait_gnt(2'b01, 8);
    req = 0;
    r_vec_en = 2'b01;
    repeat (3) tick();
    r_vec_en = 0;
    rel = 2'b01;
    tick();
    rel = 0;
    check("dr_gnt", gnt, 0);
    check("dr_busy0", busy, 1);
    r_vec_en = 2'b01;
    #1;
    check("dr_en_blocked", c_vec_en, 0);
    tick();
    r_vec_en = 0;
    cordic_vec_opvld = 1;
    #1;
    check("dr_opvld", r_vec_opvld, 2'b01);
    repeat (3) tick();
    cordic_vec_opvld = 0;
    check("dr_busy3", busy, 1);
    tick();
    check("dr_idle", busy, 0);

    // same-cycle en and opvld on rot1
    r_rot1_microRot = {16'hA5A5, 16'h1234};
    r_rot1_quad = {2'b10, 2'b01};
    req = 2'b10;
    wait_gnt(2'b10, 8);
    req = 0;
    r_rot1_en = 2'b10;
    #1;
    check("se_mr", c_mr, 16'hA5A5);
    check("se_quad", c_q, 2'b10);
    tick();
    cordic_rot1_opvld = 1;
    #1;
    check("se_opvld", r_rot1_opvld, 2'b10);
    tick();
    r_rot1_en = 0;
    cordic_rot1_opvld = 0;
    rel = 2'b10;
    tick();
    rel = 0;
    check("se_busy0", busy, 1);
    tick();
    check("se_busy1", busy, 1);
    cordic_rot1_opvld = 1;
    tick();
    cordic_rot1_opvld = 0;
    check("se_busy2", busy, 1);
    tick();
    check("se_idle", busy, 0);

    // reset in the middle of a grant drops the strobe
    req = 2'b01;
    wait_gnt(2'b01, 8);
    req = 0;
    r_vec_en = 2'b01;
    tick();
    r_vec_en = 0;
    nreset = 0;
    cordic_vec_opvld = 1;
    tick();
    check("mr_gnt", gnt, 0);
    check("mr_busy", busy, 0);
    check("mr_opvld", r_vec_opvld, 0);
    check("mr_nrst", cordic_nrst, 0);
    nreset = 1;
    cordic_vec_opvld = 0;
    tick();

    // long silent grant
    req = 2'b01;
    wait_gnt(2'b01, 8);
    req = 2'b10;
    repeat (40) tick();
`ifdef CORDIC_ARB_TIMEOUT_EN
    check("tmo_seen", seen_tmo, 1);
`else
    check("hold_gnt", gnt, 2'b01);
    check("tmo_seen", seen_tmo, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ica_cordic_arbiter.md
# ica_cordic_arbiter

Time-shares the single ICA-side port pair of the shared CORDIC wrapper between N_REQ ICA sub-blocks: vectoring, plus rotation-1 with external micro-rotations. Typical requesters are the 5-D norm unit and the Gram-Schmidt update unit. The block grants the port round-robin and resets the CORDIC before each grant. It muxes the granted requester's stimulus onto the wrapper, routes valid strobes back to the granted requester only, and drains in-flight operations before re-arbitrating. It sits between the ICA sub-blocks and the CORDIC wrapper's ica_cordic_vec_* / ica_cordic_rot1_* ports, and owns the wrapper's nreset.

## Interface
- N_REQ, 2, number of requesters (2..4)
- DATA_WIDTH, 32, CORDIC data word width
- CORDIC_STAGES, 16, micro-rotation vector width
- RST_CYCLES, 2, cycles cordic_nrst is held low before each grant (≥1)
- MAX_OUT, 15, maximum outstanding operations per CORDIC path
- TIMEOUT_CYCLES, 4096, idle-grant limit (used only with the configuration macro)

Ports are listed clock and reset first. "[N]" means a per-requester vector; "[N×W]" means flattened, with requester i at bits [i*W +: W].
- clk  in  1  clock
- nreset  in  1  synchronous, active-low reset
- req  in  [N]  request, level; held until granted
- rel  in  [N]  release pulse; only the granted requester's rel is honoured
- gnt  out  [N]  one-hot grant, registered
- r_vec_en, r_vec_angle_calc_en, r_rot1_en, r_rot1_angle_microRot_n, r_rot1_microRot_ext_vld  in  [N]  per-requester controls
- r_vec_xin, r_vec_yin, r_rot1_xin, r_rot1_yin  in  [N×DATA_WIDTH]
- r_rot1_microRot  in  [N×CORDIC_STAGES];  r_rot1_quad  in  [N×2]
- ica_cordic_vec_en, _vec_angle_calc_en, _rot1_en, _rot1_angle_microRot_n, _rot1_microRot_ext_vld  out  1  to wrapper
- ica_cordic_vec_xin, _vec_yin, _rot1_xin, _rot1_yin  out  DATA_WIDTH;  ica_cordic_rot1_microRot_in  out  CORDIC_STAGES;  ica_cordic_rot1_quad_in  out  2
- cordic_nrst  out  1  wrapper reset, registered
- cordic_vec_opvld, cordic_rot1_opvld  in  1  from wrapper
- r_vec_opvld, r_rot1_opvld  out  [N]  strobe routed to the owner requester only
- busy  out  1  state ≠ IDLE
- timeout  out  1  sticky timeout flag

CORDIC data outputs are not routed through this block; they go directly to all requesters.

## Operation
State machine: IDLE → CRST → GRANT → DRAIN → IDLE.
- **IDLE**
  - Select the first i with req[i]=1, scanning from ptr, ptr+1, … mod N_REQ.
  - Latch the owner index and go to CRST.
  - After reset, ptr=0.
- **CRST**
  - cordic_nrst=0 for exactly RST_CYCLES cycles, then go to GRANT.
- **GRANT**
  - gnt[owner]=1.
  - All wrapper inputs are combinationally muxed from the owner.
  - Inputs from non-owners are ignored.
  - On rel[owner] go to DRAIN; ptr ← owner+1 mod N_REQ.
- **DRAIN**
  - gnt=0 and all wrapper enables are forced 0.
  - Go to IDLE when both outstanding counters are 0.
- **Wrapper inputs outside GRANT:** all enables and data are driven 0.
- **Outstanding counters** (vec, rot1), each 0..MAX_OUT:
  - +1 on an accepted en; −1 on the matching opvld.
  - en and opvld in the same cycle leave the counter unchanged.
  - Saturate at MAX_OUT; never decrement below 0.
- **opvld routing:** strobes are routed to the owner in GRANT and DRAIN. Strobes arriving in IDLE/CRST are dropped.
- **rel held across cycles:** acts once.
- **req deasserted before grant:** never happens (protocol rule); the grant proceeds regardless.

## Timing
- **Reset values:** gnt=0, cordic_nrst=0, all wrapper enables/data 0, r_*_opvld=0, busy=0, timeout=0, counters=0, ptr=0, state=IDLE.
- **req → gnt:** req sampled at edge k gives gnt high from edge k+1+RST_CYCLES. With defaults, gnt is high 3 cycles after req is sampled.
- **cordic_nrst:** low during reset and CRST, high otherwise.
- **Stimulus path:** combinational, zero added latency. The wrapper sees the en in the same cycle the requester drives it.
- **rel sampled at edge k:** gnt=0 from edge k+1. Earliest re-grant is DRAIN-exit + 1 + RST_CYCLES.
- **nreset low mid-operation:** everything returns to reset values at the next edge. In-flight opvld strobes are dropped.

## Configuration
- **CORDIC_ARB_TIMEOUT_EN defined:**
  - In GRANT, a cycle counter clears on any owner en or routed opvld.
  - When the counter reaches TIMEOUT_CYCLES, the block forces the state to CRST (counters cleared), sets timeout=1, and advances ptr to owner+1.
  - timeout clears on the next grant.
- **Not defined:** no counter; timeout is tied 0.

## Test plan
- **Reset:** nreset=0 for 3 cycles → all outputs at reset values, cordic_nrst=0; 1 cycle after release, cordic_nrst=1.
- **Single grant:** req[0]=1 → cordic_nrst low 2 cycles; gnt=01 on cycle 3.
  - r_vec_xin[0]=0x00100000 appears on ica_cordic_vec_xin in the same cycle.
  - The opvld strobe appears on r_vec_opvld[0] only.
- **Contention:** req=11 from IDLE after reset → requester 0 granted first. After rel[0] and drain, requester 1 is granted without re-request; ptr alternates 0,1,0.
- **Drain:** 3 vec_en pulses, rel issued before any opvld → gnt drops next cycle and busy stays 1. IDLE is reached only after the 3rd cordic_vec_opvld. An en from requester 0 during DRAIN does not reach the wrapper.
- **Simultaneous en+opvld:** 1 outstanding, then an en and an opvld in the same cycle → counter stays 1; DRAIN exits after one more opvld.
- **Timeout (macro on, TIMEOUT_CYCLES=16):** requester granted, then 16 silent cycles → timeout=1, cordic_nrst low RST_CYCLES, then requester 1 granted. Macro off → grant held indefinitely and timeout=0.
